// File: rtl/fdivsqrt_pkg.sv
// rtl/fdivsqrt_pkg.sv - shared types and constants for the divide/sqrt iteration controller
// Purpose: state encoding and default step-counter width.
// Ports: none (package).
package fdivsqrt_pkg;

  localparam int DURLEN_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fdivsqrt_stepcnt.sv
// rtl/fdivsqrt_stepcnt.sv - loadable down-counter holding the remaining iteration count
// Purpose: DURLEN-bit step counter; priority reset > clr > load > dec.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load, load_val     : load a new count
//   dec                : decrement by one (caller guarantees count >= 1)
//   clr                : clear to zero
//   count              : current count
//   is_one             : count == 1
module fdivsqrt_stepcnt #(
  parameter int DURLEN = fdivsqrt_pkg::DURLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DURLEN-1:0] load_val,
  input  logic              dec,
  input  logic              clr,
  output logic [DURLEN-1:0] count,
  output logic              is_one
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - DURLEN'(1);
    end
  end

  assign is_one = (count == DURLEN'(1));

endmodule

// File: rtl/fdivsqrt_iter_fsm.sv
// rtl/fdivsqrt_iter_fsm.sv - iteration sequencer for the divide/square-root recurrence
// Purpose: accepts a start, enables the recurrence for max(CyclesE,1) cycles, then
//   presents ValidM until M accepts it. Flush aborts in any state.
// Optional feature: FDIVSQRT_SPECIALCASE_BYPASS_EN - when defined, a special-case
//   start skips the iterations and goes straight to DONE.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   StartE         : start request (sampled in IDLE only)
//   CyclesE        : iteration count, sampled with StartE
//   SpecialCaseE   : special-case operand, sampled with StartE
//   FlushE         : abort, highest priority after reset
//   StallM         : M stage cannot accept the result
//   BusyE          : unit occupied
//   IterE          : perform one recurrence step
//   FirstIterE     : first recurrence step of the operation
//   StepE          : iterations remaining including the current one
//   ValidM         : result valid to M
module fdivsqrt_iter_fsm
  import fdivsqrt_pkg::*;
#(
  parameter int DURLEN = DURLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartE,
  input  logic [DURLEN-1:0] CyclesE,
  input  logic              SpecialCaseE,
  input  logic              FlushE,
  input  logic              StallM,
  output logic              BusyE,
  output logic              IterE,
  output logic              FirstIterE,
  output logic [DURLEN-1:0] StepE,
  output logic              ValidM
);

`ifdef FDIVSQRT_SPECIALCASE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  fsm_state_t        state;
  logic              cnt_load;
  logic              cnt_dec;
  logic [DURLEN-1:0] cnt_load_val;
  logic              cnt_is_one;
  logic              bypass;

  // A zero count still needs one pass through the recurrence.
  assign cnt_load_val = (CyclesE == '0) ? DURLEN'(1) : CyclesE;
  assign cnt_load     = (state == IDLE) && StartE && !FlushE;
  assign cnt_dec      = (state == BUSY) && !FlushE;
  assign bypass       = BYPASS_EN && SpecialCaseE;

  fdivsqrt_stepcnt #(.DURLEN(DURLEN)) u_stepcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clr      (FlushE),
    .count    (StepE),
    .is_one   (cnt_is_one)
  );

  // Outputs are registered alongside the state so none depends on StartE combinationally.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      state      <= IDLE;
      BusyE      <= 1'b0;
      IterE      <= 1'b0;
      FirstIterE <= 1'b0;
      ValidM     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            BusyE <= 1'b1;
            if (bypass) begin
              state  <= DONE;
              ValidM <= 1'b1;
            end else begin
              state      <= BUSY;
              IterE      <= 1'b1;
              FirstIterE <= 1'b1;
            end
          end
        end
        BUSY: begin
          FirstIterE <= 1'b0;
          if (cnt_is_one) begin
            state  <= DONE;
            IterE  <= 1'b0;
            ValidM <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE first means a start in the accept cycle is not taken.
          if (!StallM) begin
            state  <= IDLE;
            BusyE  <= 1'b0;
            ValidM <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          BusyE      <= 1'b0;
          IterE      <= 1'b0;
          FirstIterE <= 1'b0;
          ValidM     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdivsqrt_iter_fsm.sv
// tb/tb_fdivsqrt_iter_fsm.sv - directed table-driven bench for fdivsqrt_iter_fsm
module tb_fdivsqrt_iter_fsm;

  logic       clk;
  logic       reset;
  logic       StartE;
  logic [5:0] CyclesE;
  logic       SpecialCaseE;
  logic       FlushE;
  logic       StallM;
  logic       BusyE;
  logic       IterE;
  logic       FirstIterE;
  logic [5:0] StepE;
  logic       ValidM;

  int checks = 0;
  int errors = 0;

  fdivsqrt_iter_fsm #(.DURLEN(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .StartE       (StartE),
    .CyclesE      (CyclesE),
    .SpecialCaseE (SpecialCaseE),
    .FlushE       (FlushE),
    .StallM       (StallM),
    .BusyE        (BusyE),
    .IterE        (IterE),
    .FirstIterE   (FirstIterE),
    .StepE        (StepE),
    .ValidM       (ValidM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied during one cycle and the outputs expected in the next cycle.
  typedef struct {
    logic       rst;
    logic       start;
    logic [5:0] cyc;
    logic       fl;
    logic       st;
    logic       busy;
    logic       iter;
    logic       first;
    logic [5:0] step;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic start, input int cyc,
                              input logic fl, input logic st, input logic busy,
                              input logic iter, input logic first, input int step,
                              input logic valid);
    vec_t v;
    v.rst = rst; v.start = start; v.cyc = 6'(cyc); v.fl = fl; v.st = st;
    v.busy = busy; v.iter = iter; v.first = first; v.step = 6'(step); v.valid = valid;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic busy, input logic iter,
                         input logic first, input logic [5:0] step, input logic valid);
    chk("BusyE", idx, int'(BusyE), int'(busy));
    chk("IterE", idx, int'(IterE), int'(iter));
    chk("FirstIterE", idx, int'(FirstIterE), int'(first));
    chk("StepE", idx, int'(StepE), int'(step));
    chk("ValidM", idx, int'(ValidM), int'(valid));
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; CyclesE = '0; SpecialCaseE = 1'b0;
    FlushE = 1'b0; StallM = 1'b0;

    //                rst st cyc fl stl   busy it fi step vld
    // reset state
    vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // CyclesE=5: IterE t1..t5, StepE 5..1, ValidM t6, idle t7
    vecs.push_back(mk(0, 1, 5, 0, 0,   1, 1, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // CyclesE=0 treated as one iteration
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // CyclesE=4, stalled 3 cycles in DONE, StartE ignored in DONE and accept cycle
    vecs.push_back(mk(0, 1, 4, 0, 0,   1, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9, 0, 1,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9, 0, 1,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // CyclesE=8 flushed at t3, new start at t4
    vecs.push_back(mk(0, 1, 8, 0, 0,   1, 1, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 6, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0,   1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 1));
    // flush beats a held result, and a start in the same cycle as flush
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // reset mid-BUSY at StepE=3
    vecs.push_back(mk(0, 1, 6, 0, 0,   1, 1, 1, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // largest count
    vecs.push_back(mk(0, 1, 63, 0, 0,  1, 1, 1, 63, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1, 0, 62, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; StartE = vecs[i].start; CyclesE = vecs[i].cyc;
      FlushE = vecs[i].fl; StallM = vecs[i].st; SpecialCaseE = 1'b0;
      cyc();
      chk_all(i, vecs[i].busy, vecs[i].iter, vecs[i].first, vecs[i].step, vecs[i].valid);
    end

    // Special-case operand with CyclesE=7
    reset = 1'b0; FlushE = 1'b0; StallM = 1'b0;
    StartE = 1'b1; SpecialCaseE = 1'b1; CyclesE = 6'd7;
    cyc();
    StartE = 1'b0; SpecialCaseE = 1'b0; CyclesE = '0;
`ifdef FDIVSQRT_SPECIALCASE_BYPASS_EN
    chk("sc_valid", 0, int'(ValidM), 1);
    chk("sc_iter", 0, int'(IterE), 0);
    chk("sc_busy", 0, int'(BusyE), 1);
    cyc();
    chk("sc_idle", 0, int'(BusyE), 0);
    chk("sc_valid_drop", 0, int'(ValidM), 0);
`else
    for (int k = 0; k < 7; k++) begin
      chk("sc_iter", k, int'(IterE), 1);
      chk("sc_step", k, int'(StepE), 7 - k);
      chk("sc_first", k, int'(FirstIterE), (k == 0) ? 1 : 0);
      chk("sc_valid", k, int'(ValidM), 0);
      cyc();
    end
    chk("sc_valid_t8", 0, int'(ValidM), 1);
    chk("sc_iter_t8", 0, int'(IterE), 0);
    cyc();
    chk("sc_idle", 0, int'(BusyE), 0);
    chk("sc_valid_drop", 0, int'(ValidM), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_iter_fsm.md
# fdivsqrt_iter_fsm

Iteration controller for the divide/square-root unit. It consumes the cycle count produced by the cycle-count logic (`CyclesE`) and sequences the recurrence datapath. It accepts a start request and asserts the iterate enable for exactly the requested number of cycles. It then presents a result-valid to the M stage and holds it until the result is accepted, honouring flush and stall throughout.

## Interface
- `DURLEN`, default 6: width of the cycle count / step counter.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high reset.
- `StartE  in  1`: request to begin a divide/sqrt operation. Sampled only in IDLE.
- `CyclesE  in  DURLEN`: number of recurrence iterations required. Sampled with `StartE`.
- `SpecialCaseE  in  1`: operand is a special case (zero/inf/NaN/div-by-zero). Sampled with `StartE`.
- `FlushE  in  1`: pipeline flush. Aborts any operation.
- `StallM  in  1`: M stage cannot accept a result this cycle.
- `BusyE  out  1`: unit occupied (BUSY or DONE). The hazard unit stalls issue on it.
- `IterE  out  1`: datapath performs one recurrence step this cycle.
- `FirstIterE  out  1`: first iteration of an operation. The datapath selects initial residual.
- `StepE  out  DURLEN`: iterations remaining, including the current one.
- `ValidM  out  1`: result is valid and presented to M.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**, when `StartE & ~FlushE`:
  - Latch `Step = max(CyclesE,1)`. A count of 0 is treated as 1.
  - Next state is BUSY.
  - If `SpecialCaseE` and the bypass is enabled, next state is DONE instead and no iterations occur.
- **BUSY**:
  - `IterE=1`; `Step` decrements by 1 each cycle.
  - When `Step==1`, next state is DONE.
  - `FirstIterE=1` only in the first BUSY cycle after start.
- **DONE**:
  - `ValidM=1`.
  - When `~StallM`, the result is accepted and next state is IDLE. Otherwise DONE holds with all outputs stable.
- `BusyE = (state != IDLE)`. `StartE` is ignored outside IDLE. No back-to-back start in the DONE→IDLE accept cycle.
- `FlushE` in any state: next state is IDLE and `Step` is cleared to 0.
  - `FlushE` has priority over start, decrement and accept.
  - `IterE` still reflects the current state in the flush cycle. The datapath ignores it under flush.
- `reset` takes priority over everything: state IDLE, `Step=0`.
- Counter arithmetic is unsigned DURLEN-bit. The counter never wraps, because the decrement occurs only in BUSY with `Step>=1`.

## Timing
- Reset values:
  - `BusyE=0`, `IterE=0`, `FirstIterE=0`, `ValidM=0`, `StepE=0`.
- All outputs are decoded from registered state and count. There is no combinational path from `StartE` to any output.
- Start accepted in cycle t:
  - BUSY occupies cycles t+1 … t+N, where N = max(CyclesE,1).
  - DONE is entered at t+N+1. `ValidM` rises at t+N+1.
- Special-case bypass: `ValidM` rises at t+1.
- Acceptance: `ValidM` drops the cycle after the first DONE cycle with `StallM=0`.
- Flush: all outputs are at their reset values the cycle after `FlushE`.

## Configuration
- `FDIVSQRT_SPECIALCASE_BYPASS_EN`:
  - Defined: a special-case start goes directly IDLE→DONE, so latency is 1 cycle.
  - Undefined: `SpecialCaseE` is ignored and special cases run the full N iterations.

## Structure
- `fdivsqrt_pkg` holds:
  - the state typedef (`enum logic [1:0] {IDLE, BUSY, DONE}`);
  - the `DURLEN` default constant.
- One sub-module, `fdivsqrt_stepcnt`: a DURLEN-bit loadable down-counter with load/decrement/clear inputs and a `==1` flag. The FSM drives it.

## Test plan
- `CyclesE=5`, `StartE` at t0, `StallM=0`:
  - `IterE` is high for t1–t5 and `FirstIterE` only at t1.
  - `StepE` reads 5,4,3,2,1.
  - `ValidM` is high only at t6, and `BusyE` is low at t7.
- `CyclesE=0`: exactly one `IterE` cycle (t1) and `ValidM` at t2.
- `CyclesE=4` with `StallM=1` for 3 cycles in DONE:
  - `ValidM` is held for 4 cycles and `StepE`/state are stable.
  - `StartE` during DONE is ignored.
- `CyclesE=8`, `FlushE` at t3:
  - At t4 the state is IDLE, `StepE=0` and `IterE=0`, and `ValidM` never asserts.
  - A new start at t4 is accepted.
- `SpecialCaseE=1`, `CyclesE=7`:
  - With the macro: `ValidM` at t1 and no `IterE`.
  - Without the macro: 7 `IterE` cycles, then `ValidM` at t8.
- `reset` asserted mid-BUSY (`StepE=3`): all outputs are 0 the next cycle and the FSM is in IDLE.
